// File: rtl/drbg_request_arbiter.sv
// Arbitrates two consumers onto one DRBG. A reseed request takes priority over generate requests,
// and every wait on the DRBG is bounded by a timeout counter.
module drbg_request_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [1:0]            req,
    output logic [1:0]            gnt_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  drbg_next_seed,
    output logic                  drbg_next_bits,
    input  logic [DATA_WIDTH-1:0] drbg_random_bits,
    input  logic                  drbg_bits_ready,
    input  logic                  drbg_init_ready,
    input  logic                  drbg_busy,
    output logic                  reseed_pending,
    output logic                  timeout_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, RESEED, WAIT_SEED, ISSUE, WAIT_BITS, DELIVER
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  pending_q, pending_d;
    logic                  err_q, err_d;
    logic                  seen_busy_q, seen_busy_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  timeout_hit;
    logic                  reseed_req;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    // A pulse arriving in IDLE is honoured the same cycle, so reseed still beats a coincident request.
    assign reseed_req  = pending_q | frame_start;

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        pending_d      = pending_q | frame_start;
        err_d          = err_q;
        seen_busy_d    = 1'b0;
        data_d         = data_q;
        gnt_valid      = 2'b00;
        drbg_next_seed = 1'b0;
        drbg_next_bits = 1'b0;

        case (state_q)
            IDLE: begin
                if (reseed_req && !drbg_busy) begin
                    state_d   = RESEED;
                    pending_d = 1'b0;
                end else if ((|req) && drbg_init_ready && !drbg_busy) begin
                    state_d = ISSUE;
                    owner_d = (req == 2'b11) ? ~last_owner_q : req[1];
                end
            end
            RESEED: begin
                drbg_next_seed = 1'b1;
                state_d        = WAIT_SEED;
            end
            WAIT_SEED: begin
                seen_busy_d = seen_busy_q | drbg_busy;
                if (seen_busy_q && !drbg_busy && drbg_init_ready) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ISSUE: begin
                drbg_next_bits = 1'b1;
                state_d        = WAIT_BITS;
            end
            WAIT_BITS: begin
                if (drbg_bits_ready) begin
                    data_d  = drbg_random_bits;
                    state_d = DELIVER;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DELIVER: begin
                gnt_valid    = owner_q ? 2'b10 : 2'b01;
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            seen_busy_q  <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            seen_busy_q  <= seen_busy_d;
            data_q       <= data_d;
        end
    end

    assign data_out       = data_q;
    assign reseed_pending = pending_q;
    assign timeout_err    = err_q;

endmodule

// File: doc/drbg_request_arbiter.md
DRBG_REQUEST_ARBITER -- requirements
Module: drbg_request_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 256, width of random block passed from DRBG to requesters.
REQ-002 Parameter TIMEOUT, default 4096, max cycles allowed in a DRBG wait state.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse at V rising; requests a DRBG reseed.
REQ-007 req  in  2  level request per consumer (consumer need_next); bit 0 = consumer 0.
REQ-008 gnt_valid  out  2  one-hot, one-cycle pulse; data_out valid for that consumer.
REQ-009 data_out  out  DATA_WIDTH  registered copy of the last DRBG block.
REQ-010 drbg_next_seed  out  1  one-cycle reseed strobe to DRBG.
REQ-011 drbg_next_bits  out  1  one-cycle generate strobe to DRBG.
REQ-012 drbg_random_bits  in  DATA_WIDTH  DRBG output block.
REQ-013 drbg_bits_ready  in  1  DRBG block-valid pulse.
REQ-014 drbg_init_ready  in  1  DRBG seeded and usable.
REQ-015 drbg_busy  in  1  DRBG computing.
REQ-016 reseed_pending  out  1  reseed requested, not yet issued.
REQ-017 timeout_err  out  1  sticky; a wait state hit TIMEOUT.

Function
REQ-018 FSM states SHALL be IDLE, RESEED, WAIT_SEED, ISSUE, WAIT_BITS, DELIVER.
REQ-019 frame_start SHALL set reseed_pending in any state; it clears only on the cycle the FSM enters RESEED; repeated pulses before then SHALL collapse to one reseed.
REQ-020 IDLE: if reseed_pending and !drbg_busy -> RESEED (reseed has priority over requests).
REQ-021 IDLE: else if |req and drbg_init_ready and !drbg_busy -> ISSUE; owner latched this cycle.
REQ-022 Arbitration: single req wins; both set -> winner is !last_owner; last_owner updates only in DELIVER.
REQ-023 RESEED: drbg_next_seed=1 for exactly this cycle -> WAIT_SEED.
REQ-024 WAIT_SEED: after drbg_busy seen high at least once, drbg_busy=0 and drbg_init_ready=1 -> IDLE.
REQ-025 ISSUE: drbg_next_bits=1 for exactly this cycle -> WAIT_BITS.
REQ-026 WAIT_BITS: drbg_bits_ready=1 -> data_out<=drbg_random_bits, -> DELIVER; frame_start here only sets reseed_pending, the transaction completes.
REQ-027 DELIVER: gnt_valid[owner]=1 for one cycle -> IDLE; delivery SHALL occur even if req[owner] dropped.
REQ-028 Latency: req sampled in IDLE at cycle t -> drbg_next_bits at t+1; bits_ready at cycle u -> gnt_valid at u+1, data_out stable from u+1 until next capture.
REQ-029 Wait counter: 0 on entering WAIT_SEED/WAIT_BITS, +1 per cycle there; reaching TIMEOUT-1 SHALL set timeout_err and go IDLE without gnt_valid.
REQ-030 Exactly one strobe (next_seed or next_bits) SHALL be asserted per transaction; never both in one cycle.
REQ-031 drbg_bits_ready outside WAIT_BITS SHALL be ignored (no capture, no grant).

Reset
REQ-032 reset SHALL force: state IDLE, gnt_valid=0, drbg_next_seed=0, drbg_next_bits=0, data_out=0, reseed_pending=0, timeout_err=0, wait counter 0, last_owner=1 (consumer 0 wins first tie).
REQ-033 reset mid-transaction SHALL abandon it; a later drbg_bits_ready SHALL produce no grant.
REQ-034 reset coincident with frame_start: reset wins, reseed_pending=0.

Verification
REQ-035 req=2'b11 held, DRBG model answers bits_ready 3 cycles after next_bits with blocks A,B,C -> gnt_valid sequence 01,10,01 with data A,B,C.
REQ-036 frame_start while req=2'b01 in IDLE, DRBG idle -> next_seed pulse first, next_bits only after busy high then low with init_ready=1.
REQ-037 frame_start during WAIT_BITS -> current grant delivered, then RESEED before any further next_bits.
REQ-038 Two frame_start pulses 5 cycles apart while busy=1 -> exactly one next_seed.
REQ-039 DRBG never asserts bits_ready, TIMEOUT=16 -> timeout_err=1 at 16th wait cycle, FSM IDLE, no gnt_valid.
REQ-040 reset in WAIT_BITS then bits_ready -> gnt_valid stays 0, data_out=0.
